// File: rtl/truth_table_sweeper_if.sv
// Stimulus/response bundle between the truth-table sweeper and the 4-input
// function under test plus whoever consumes the sweep results.
//   start      : sweep request (sampled only while the sweeper is idle)
//   F          : function output fed back to the sweeper
//   A,B,C,D    : stimulus vector, A is the MSB
//   busy, done : sweep in progress / one-cycle results-valid pulse
//   pass, tbl, err_count, first_bad : sweep results (tbl bit k = F at vector k)
interface truth_table_sweeper_if;
  localparam int unsigned N_VEC   = 16;
  localparam int unsigned ERR_W   = 5;
  localparam int unsigned IDX_W   = 4;

  logic               start;
  logic               F;
  logic               A;
  logic               B;
  logic               C;
  logic               D;
  logic               busy;
  logic               done;
  logic               pass;
  logic [N_VEC-1:0]   tbl;
  logic [ERR_W-1:0]   err_count;
  logic [IDX_W-1:0]   first_bad;

  // Sweeper side.
  modport master (
    input  start, F,
    output A, B, C, D, busy, done, pass, tbl, err_count, first_bad
  );

  // Requester / function-under-test side.
  modport slave (
    output start, F,
    input  A, B, C, D, busy, done, pass, tbl, err_count, first_bad
  );
endinterface

// File: rtl/truth_table_sweeper.sv
// Walks the 4-input function under test through vectors 0..15, holds each
// vector SETTLE cycles before sampling F, builds the 16-bit truth table and
// compares it against EXPECTED at the end of the sweep.
//   clk   : rising-edge clock
//   reset : synchronous active-high reset, dominates everything
//   bus   : truth_table_sweeper_if master (start/F in; A..D, busy, done,
//           pass, tbl, err_count, first_bad out; all outputs registered)
module truth_table_sweeper #(
  parameter int unsigned SETTLE   = 2,
  parameter logic [15:0] EXPECTED = 16'hF830
) (
  input  logic                   clk,
  input  logic                   reset,
  truth_table_sweeper_if.master  bus
);

  localparam int unsigned N_VEC  = 16;
  localparam int unsigned IDX_W  = 4;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned ERR_W  = 5;
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(N_VEC - 1);
  // Settle-counter value on the last WAIT cycle of a vector.
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'((SETTLE == 0) ? 0 : SETTLE - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [IDX_W-1:0]   abcd_q;
  logic [N_VEC-1:0]   tbl_q;
  logic               pass_q;
  logic [ERR_W-1:0]   err_q;
  logic [IDX_W-1:0]   first_q;
  logic               busy_q;
  logic               done_q;

  logic               busy_d;
  logic               done_d;
  logic [N_VEC-1:0]   tbl_upd;
  logic [N_VEC-1:0]   diff;
  logic [ERR_W-1:0]   err_d;
  logic [IDX_W-1:0]   first_d;
  logic               found;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (bus.start) state_d = (SETTLE == 0) ? S_SAMPLE : S_WAIT;
      S_WAIT:   if (cnt_q == SETTLE_LAST) state_d = S_SAMPLE;
      S_SAMPLE: begin
        if (idx_q == LAST_IDX) state_d = S_DONE;
        else                   state_d = (SETTLE == 0) ? S_SAMPLE : S_WAIT;
      end
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output/result decode: status flags follow the next state so they are
  // registered, and the result fields are derived from the table including
  // the sample being taken this cycle.
  always_comb begin
    busy_d  = (state_d == S_WAIT) || (state_d == S_SAMPLE);
    done_d  = (state_d == S_DONE);
    tbl_upd = tbl_q;
    tbl_upd[idx_q] = bus.F;
    diff    = tbl_upd ^ EXPECTED;
    err_d   = '0;
    first_d = '0;
    found   = 1'b0;
    for (int i = 0; i < int'(N_VEC); i++) begin
      err_d = err_d + ERR_W'(diff[i]);
      if (diff[i] && !found) begin
        first_d = IDX_W'(i);
        found   = 1'b1;
      end
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q   <= '0;
      cnt_q   <= '0;
      abcd_q  <= '0;
      tbl_q   <= '0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      first_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            idx_q   <= '0;
            cnt_q   <= '0;
            abcd_q  <= '0;
            tbl_q   <= '0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            first_q <= '0;
          end
        end
        S_WAIT: cnt_q <= cnt_q + CNT_W'(1);
        S_SAMPLE: begin
          tbl_q <= tbl_upd;
          if (idx_q == LAST_IDX) begin
            abcd_q  <= '0;
            pass_q  <= (diff == '0);
            err_q   <= err_d;
            first_q <= first_d;
          end else begin
            idx_q  <= idx_q + IDX_W'(1);
            abcd_q <= idx_q + IDX_W'(1);
            cnt_q  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.A         = abcd_q[3];
  assign bus.B         = abcd_q[2];
  assign bus.C         = abcd_q[1];
  assign bus.D         = abcd_q[0];
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.tbl       = tbl_q;
  assign bus.err_count = err_q;
  assign bus.first_bad = first_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: a SETTLE=2 and a SETTLE=0 instance, each
// driven by a truth-table lookup acting as the function under test, checked
// every cycle against a timeline model of the sweep.
module tb_truth_table_sweeper;

  localparam logic [15:0] EXP = 16'hF830;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  truth_table_sweeper_if bus0 ();
  truth_table_sweeper_if bus1 ();

  truth_table_sweeper #(.SETTLE(2)) dut0 (.clk(clk), .reset(reset), .bus(bus0.master));
  truth_table_sweeper #(.SETTLE(0)) dut1 (.clk(clk), .reset(reset), .bus(bus1.master));

  // Function under test for each instance, as a 16-entry lookup.
  logic [15:0] ftab [2];
  assign bus0.F = ftab[0][{bus0.A, bus0.B, bus0.C, bus0.D}];
  assign bus1.F = ftab[1][{bus1.A, bus1.B, bus1.C, bus1.D}];

  logic [3:0]  d_abcd  [2];
  logic        d_busy  [2];
  logic        d_done  [2];
  logic        d_pass  [2];
  logic [15:0] d_tbl   [2];
  logic [4:0]  d_err   [2];
  logic [3:0]  d_first [2];
  assign d_abcd[0]  = {bus0.A, bus0.B, bus0.C, bus0.D};
  assign d_abcd[1]  = {bus1.A, bus1.B, bus1.C, bus1.D};
  assign d_busy[0]  = bus0.busy;       assign d_busy[1]  = bus1.busy;
  assign d_done[0]  = bus0.done;       assign d_done[1]  = bus1.done;
  assign d_pass[0]  = bus0.pass;       assign d_pass[1]  = bus1.pass;
  assign d_tbl[0]   = bus0.tbl;        assign d_tbl[1]   = bus1.tbl;
  assign d_err[0]   = bus0.err_count;  assign d_err[1]   = bus1.err_count;
  assign d_first[0] = bus0.first_bad;  assign d_first[1] = bus1.first_bad;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;
  int done_cnt [2] = '{0, 0};

  task automatic check(input string name, input int inst, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s[inst%0d] @%0t: got 0x%0h, expected 0x%0h", name, inst, $time, act, exp);
    end
  endtask

  // Cycles per vector for each instance.
  function automatic int per(input int i);
    return (i == 0) ? 3 : 1;
  endfunction

  function automatic int popc(input logic [15:0] v);
    int n = 0;
    for (int k = 0; k < 16; k++) if (v[k]) n++;
    return n;
  endfunction

  function automatic int lowest(input logic [15:0] v);
    int r = 0;
    for (int k = 15; k >= 0; k--) if (v[k]) r = k;
    return r;
  endfunction

  // F = A(B + CD) + B.!C evaluated per vector.
  function automatic logic [15:0] real_func();
    logic [15:0] t;
    logic [3:0]  v;
    for (int k = 0; k < 16; k++) begin
      v = 4'(k);
      t[k] = (v[3] & (v[2] | (v[1] & v[0]))) | (v[2] & ~v[1]);
    end
    return t;
  endfunction

  // Model: phase = edges since the accepting edge (-1 when idle).
  int          phase  [2] = '{-1, -1};
  logic [15:0] ft_sw  [2];
  logic [15:0] m_tbl  [2];
  logic        m_pass [2];
  int          m_err  [2];
  int          m_first[2];

  always @(posedge clk) begin
    logic st;
    for (int i = 0; i < 2; i++) begin
      st = (i == 0) ? bus0.start : bus1.start;
      if (reset) begin
        phase[i] = -1;
        m_tbl[i] = '0; m_pass[i] = 1'b0; m_err[i] = 0; m_first[i] = 0;
      end else if (phase[i] < 0) begin
        if (st) begin
          phase[i] = 0;
          ft_sw[i] = ftab[i];
          m_tbl[i] = '0; m_pass[i] = 1'b0; m_err[i] = 0; m_first[i] = 0;
        end
      end else if (phase[i] == 16 * per(i)) begin
        phase[i] = -1;
      end else begin
        phase[i]++;
        if (phase[i] == 16 * per(i)) begin
          m_tbl[i]   = ft_sw[i];
          m_pass[i]  = (ft_sw[i] == EXP);
          m_err[i]   = popc(ft_sw[i] ^ EXP);
          m_first[i] = lowest(ft_sw[i] ^ EXP);
        end
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    int p, pp, ns;
    logic [3:0] ea;
    logic eb, ed, ep;
    logic [15:0] et, mask;
    int ee, ef;
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        p  = phase[i];
        pp = per(i);
        if (d_done[i] === 1'b1) done_cnt[i]++;
        if (p < 0 || p == 16 * pp) begin
          ea = '0; eb = 1'b0; ed = (p >= 0);
          et = m_tbl[i]; ep = m_pass[i]; ee = m_err[i]; ef = m_first[i];
        end else begin
          ns   = p / pp;
          mask = 16'((32'd1 << ns) - 32'd1);
          ea = 4'(ns); eb = 1'b1; ed = 1'b0;
          et = ft_sw[i] & mask; ep = 1'b0; ee = 0; ef = 0;
        end
        check("abcd", i, 32'(d_abcd[i]), 32'(ea));
        check("busy", i, 32'(d_busy[i]), 32'(eb));
        check("done", i, 32'(d_done[i]), 32'(ed));
        check("tbl", i, 32'(d_tbl[i]), 32'(et));
        check("pass", i, 32'(d_pass[i]), 32'(ep));
        check("err_count", i, 32'(d_err[i]), 32'(ee));
        check("first_bad", i, 32'(d_first[i]), 32'(ef));
      end
    end
  end

  task automatic set_start(input int i, input logic v);
    if (i == 0) bus0.start = v;
    else        bus1.start = v;
  endtask

  // Pulse start from idle; returns at the negedge of the done cycle with
  // n = edges from the accepting edge to the edge before done (200 = timeout).
  task automatic run_sweep(input int i, output int n);
    @(negedge clk);
    set_start(i, 1'b1);
    @(posedge clk);
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      set_start(i, 1'b0);
      if (d_done[i] === 1'b1) break;
      @(posedge clk);
      n++;
    end
    if (n >= 200) check("done_timeout", i, 32'(n), 32'(16 * per(i)));
  endtask

  initial begin
    int n, d0, lowrun, gaps, dones;
    bit seen_high;
    bus0.start = 1'b0;
    bus1.start = 1'b0;
    ftab[0] = real_func();
    ftab[1] = real_func();
    reset = 1'b1;
    @(posedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_tbl", 0, 32'(d_tbl[0]), 32'h0);
    check("rst_busy", 0, 32'(d_busy[0]), 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Real function, SETTLE=2.
    d0 = done_cnt[0];
    run_sweep(0, n);
    check("latency", 0, 32'(n), 32'd48);
    check("tbl_real", 0, 32'(d_tbl[0]), 32'hF830);
    check("pass_real", 0, 32'(d_pass[0]), 32'd1);
    check("err_real", 0, 32'(d_err[0]), 32'd0);
    check("first_real", 0, 32'(d_first[0]), 32'd0);
    repeat (3) @(negedge clk);
    check("done_pulses", 0, 32'(done_cnt[0] - d0), 32'd1);
    check("abcd_after", 0, 32'(d_abcd[0]), 32'h0);

    // F tied low.
    ftab[0] = 16'h0000;
    run_sweep(0, n);
    check("tbl_zero", 0, 32'(d_tbl[0]), 32'h0);
    check("pass_zero", 0, 32'(d_pass[0]), 32'd0);
    check("err_zero", 0, 32'(d_err[0]), 32'd7);
    check("first_zero", 0, 32'(d_first[0]), 32'd4);
    repeat (2) @(negedge clk);
    check("hold_err", 0, 32'(d_err[0]), 32'd7);

    // Reset in the middle of a sweep.
    ftab[0] = real_func();
    set_start(0, 1'b1);
    @(negedge clk);
    set_start(0, 1'b0);
    repeat (19) @(negedge clk);
    d0 = done_cnt[0];
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", 0, 32'(d_busy[0]), 32'h0);
    check("abort_abcd", 0, 32'(d_abcd[0]), 32'h0);
    check("abort_tbl", 0, 32'(d_tbl[0]), 32'h0);
    repeat (60) @(negedge clk);
    check("abort_no_done", 0, 32'(done_cnt[0] - d0), 32'd0);
    run_sweep(0, n);
    check("tbl_after_abort", 0, 32'(d_tbl[0]), 32'hF830);
    check("pass_after_abort", 0, 32'(d_pass[0]), 32'd1);

    // start held high: back-to-back sweeps.
    repeat (2) @(negedge clk);
    set_start(0, 1'b1);
    lowrun = 0; gaps = 0; dones = 0; seen_high = 1'b0;
    for (int c = 0; c < 120; c++) begin
      @(negedge clk);
      if (d_done[0] === 1'b1) dones++;
      if (d_busy[0] === 1'b0) lowrun++;
      else begin
        if (seen_high && lowrun > 0) begin
          check("gap_len", 0, 32'(lowrun), 32'd2);
          gaps++;
        end
        lowrun = 0;
        seen_high = 1'b1;
      end
    end
    set_start(0, 1'b0);
    check("held_dones", 0, 32'(dones), 32'd2);
    check("held_gaps", 0, 32'(gaps), 32'd2);
    n = 0;
    while (d_busy[0] === 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("held_drain", 0, 32'(n < 200), 32'd1);
    repeat (3) @(negedge clk);

    // SETTLE=0 instance.
    run_sweep(1, n);
    check("latency_s0", 1, 32'(n), 32'd16);
    check("tbl_s0", 1, 32'(d_tbl[1]), 32'hF830);
    check("pass_s0", 1, 32'(d_pass[1]), 32'd1);
    repeat (3) @(negedge clk);

    // Random tables, random start pulses (including while busy), rare resets.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (phase[i] < 0 && ($urandom % 8) == 0)
          ftab[i] = (($urandom % 4) == 0) ? EXP : 16'($urandom);
        set_start(i, ($urandom % 6) == 0);
      end
      reset = (($urandom % 400) == 0);
    end
    reset = 1'b0;
    set_start(0, 1'b0);
    set_start(1, 1'b0);
    repeat (5) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
- Upstream stimulus stage for the 4-input combinational function block F(A,B,C,D).
- Drives the function's A, B, C and D inputs through all 16 vectors in ascending order.
- Waits a programmable settle time per vector, then samples F back into a 16-bit truth-table register.
- At the end of the sweep, compares the table against an expected mask and reports pass/fail, mismatch count and the first failing index.

Parameters:
- SETTLE, 2, cycles each vector is held before F is sampled; legal range 0..15.
- EXPECTED, 16'hF830, expected truth table; bit index = {A,B,C,D} with A as MSB. The default matches F = A(B + CD) + B·!C.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  sweep request; sampled only in IDLE.
- F  input  1  output of the function under test.
- A  output  1  stimulus bit 3 (MSB).
- B  output  1  stimulus bit 2.
- C  output  1  stimulus bit 1.
- D  output  1  stimulus bit 0 (LSB).
- busy  output  1  high in WAIT and SAMPLE states.
- done  output  1  one-cycle pulse when results are valid.
- pass  output  1  1 when table == EXPECTED; valid from done onward.
- table  output  16  captured F values; bit k = F at vector k.
- err_count  output  5  popcount(table ^ EXPECTED), range 0..16.
- first_bad  output  4  lowest mismatching index; 0 when pass=1.

Behaviour:
- Reset (synchronous, active-high, dominates all other inputs): next edge forces state IDLE.
  - All outputs go to 0, including A..D, table and the internal counters.
- States: IDLE, WAIT, SAMPLE, DONE.
- IDLE, start=1: at that edge, vector idx <= 0, {A,B,C,D} <= 4'b0000, table <= 0, err_count <= 0, first_bad <= 0, pass <= 0, settle counter <= 0.
  - Next state is WAIT, or SAMPLE directly when SETTLE=0.
- WAIT: settle counter increments each cycle.
  - After SETTLE cycles in WAIT, go to SAMPLE.
  - {A,B,C,D} = idx and is held stable throughout.
- SAMPLE (1 cycle): at the closing edge, table[idx] <= F.
  - If idx==15: go to DONE and drive {A,B,C,D} <= 0.
  - Else: idx increments, {A,B,C,D} <= idx+1, counter clears, go to WAIT (or stay in SAMPLE when SETTLE=0).
- Each vector occupies SETTLE+1 cycles.
  - Vector k is sampled at edge E0 + (k+1)(SETTLE+1), where E0 is the start-accept edge.
- DONE (1 cycle): done=1, busy=0. pass, err_count and first_bad are valid in this cycle.
  - They are computed combinationally from the final table, or registered so they are valid in the DONE cycle.
  - Next state is IDLE unconditionally.
- Results (table, pass, err_count, first_bad) hold after DONE until the next accepted start.
- start is ignored in WAIT, SAMPLE and DONE. It is not queued.
- start held high continuously: a new sweep is accepted in the IDLE cycle after DONE. busy is low for exactly 2 cycles between sweeps (DONE, IDLE).
- first_bad: priority encode from bit 0 upward over table ^ EXPECTED.
- err_count is 5 bits wide so that 16 mismatches do not overflow.
- Reset mid-sweep: the sweep aborts, there is no done pulse, and all outputs are 0. The next start performs a full clean sweep.
- Default timing (SETTLE=2): the sweep takes 48 cycles, and done is high in the cycle following edge E0+48.

Test Plan:
- Reset, 1-cycle start, F driven by the real 4-input function, SETTLE=2 -> done pulses exactly once after edge E0+48; table=16'hF830, pass=1, err_count=0, first_bad=0.
- Same stimulus, F tied to 0 -> table=16'h0000, pass=0, err_count=7, first_bad=4.
- Observe A..D with SETTLE=2 -> vectors 0000,0001,...,1111 in order, each stable 3 cycles with A as MSB; after the sweep A..D return to 0000; busy high for 48 cycles.
- Assert reset for 1 cycle at E0+20 -> all outputs 0 at the next edge and no done pulse; a subsequent start yields table=16'hF830, pass=1.
- start held high for 120 cycles -> two back-to-back sweeps, each with one done pulse; busy is low exactly 2 cycles between sweeps; pulsing start during busy has no effect.
- Instance with SETTLE=0 -> each vector held 1 cycle; done after edge E0+16; table=16'hF830, pass=1.
